// File: rtl/tlb_window_if.sv
// Bundle of install, flush, lookup and status signals between the core-side
// address path (master) and the tlb_window translator (slave).
interface tlb_window_if #(
    parameter int MEM_SLOTS_COUNT = 32,
    parameter int ENTRIES         = 4
);
    localparam int SLOT_W = $clog2(MEM_SLOTS_COUNT);
    localparam int IDX_W  = $clog2(ENTRIES);

    logic              map_valid;
    logic [31:0]       map_vbase;
    logic [SLOT_W-1:0] map_sbase;
    logic [SLOT_W:0]   map_words;
    logic              map_ready;
    logic              flush;
    logic              req_valid;
    logic [31:0]       req_vptr;
    logic              rsp_valid;
    logic              rsp_hit;
    logic              rsp_fault;
    logic [SLOT_W-1:0] rsp_slot;
    logic [IDX_W:0]    entries_used;
    logic [15:0]       miss_cnt;

    modport master (
        output map_valid, map_vbase, map_sbase, map_words, flush, req_valid, req_vptr,
        input  map_ready, rsp_valid, rsp_hit, rsp_fault, rsp_slot, entries_used, miss_cnt
    );

    modport slave (
        input  map_valid, map_vbase, map_sbase, map_words, flush, req_valid, req_vptr,
        output map_ready, rsp_valid, rsp_hit, rsp_fault, rsp_slot, entries_used, miss_cnt
    );
endinterface

// File: rtl/tlb_window.sv
// Multi-entry windowed translator: maps word-aligned virtual pointers onto data
// memory slot indices through run-time installed (vbase, sbase, words) windows.
module tlb_window #(
    parameter int MEM_SLOTS_COUNT = 32,
    parameter int ENTRIES         = 4,
    parameter int WORDSZ_BYTES    = 4
) (
    input logic        clk,
    input logic        rst_n,
    tlb_window_if.slave bus
);
    localparam int SLOT_W = $clog2(MEM_SLOTS_COUNT);
    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int SHIFT  = $clog2(WORDSZ_BYTES);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  flush_cnt, flush_cnt_next;
    logic              clear_en;
    logic              map_ready;

    logic [ENTRIES-1:0] valid, valid_next;
    logic [31:0]        vbase [ENTRIES];
    logic [SLOT_W-1:0]  sbase [ENTRIES];
    logic [SLOT_W:0]    words [ENTRIES];
    logic [IDX_W-1:0]   victim;
    logic [IDX_W:0]     used, used_next;

    logic               install;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   target;

    logic [31:0]        offs;
    logic               match;
    logic [SLOT_W-1:0]  match_slot;
    logic               fault;
    logic               hit;

    logic               rsp_valid, rsp_hit, rsp_fault;
    logic [SLOT_W-1:0]  rsp_slot;
    logic [15:0]        miss_cnt;

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        clear_en       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush) begin
                    state_next     = FLUSH;
                    flush_cnt_next = '0;
                end
            end
            FLUSH: begin
                clear_en = 1'b1;
                if (bus.flush) begin
                    flush_cnt_next = '0;
                end else if (flush_cnt == IDX_W'(ENTRIES - 1)) begin
                    state_next = IDLE;
                end else begin
                    flush_cnt_next = flush_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    assign map_ready = (state == IDLE) && !bus.flush;

    // Zero-length installs are accepted but leave the table and victim untouched.
    always_comb begin
        install    = bus.map_valid && map_ready && (bus.map_words != '0);
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        target = free_found ? free_idx : victim;
    end

    always_comb begin
        valid_next = valid;
        if (clear_en) begin
            valid_next[flush_cnt] = 1'b0;
        end
        if (install) begin
            valid_next[target] = 1'b1;
        end
        used_next = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            used_next = used_next + {{IDX_W{1'b0}}, valid_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            victim <= '0;
            used   <= '0;
        end else begin
            valid <= valid_next;
            used  <= used_next;
            if (install && !free_found) begin
                victim <= victim + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            vbase[target] <= bus.map_vbase;
            sbase[target] <= bus.map_sbase;
            words[target] <= bus.map_words;
        end
    end

    // Pointers below vbase wrap to a huge offset, so they never match.
    always_comb begin
        match      = 1'b0;
        match_slot = '0;
        offs       = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            offs = (bus.req_vptr - vbase[i]) >> SHIFT;
            if (!match && valid[i] && (offs < {{(31 - SLOT_W){1'b0}}, words[i]})) begin
                match      = 1'b1;
                match_slot = sbase[i] + offs[SLOT_W-1:0];
            end
        end
        fault = (bus.req_vptr & (32'(WORDSZ_BYTES) - 32'd1)) != 32'd0;
        hit   = match && !fault && (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_slot  <= '0;
            miss_cnt  <= '0;
        end else begin
            rsp_valid <= bus.req_valid;
            rsp_hit   <= bus.req_valid && hit;
            rsp_fault <= bus.req_valid && fault;
            rsp_slot  <= (bus.req_valid && hit) ? match_slot : '0;
            if (bus.req_valid && !hit && !fault && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign bus.map_ready    = map_ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_hit      = rsp_hit;
    assign bus.rsp_fault    = rsp_fault;
    assign bus.rsp_slot     = rsp_slot;
    assign bus.entries_used = used;
    assign bus.miss_cnt     = miss_cnt;
endmodule

// File: tb/tb_tlb_window.sv
// Self-checking bench for tlb_window: directed scenarios plus random traffic
// compared against a table-level behavioural model.
module tb_tlb_window;
    localparam int NSLOTS = 32;
    localparam int NENT   = 4;
    localparam int WBYTES = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tlb_window_if #(.MEM_SLOTS_COUNT(NSLOTS), .ENTRIES(NENT)) bus ();

    tlb_window #(.MEM_SLOTS_COUNT(NSLOTS), .ENTRIES(NENT), .WORDSZ_BYTES(WBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bit          m_valid [NENT];
    logic [31:0] m_vbase [NENT];
    int          m_sbase [NENT];
    int          m_words [NENT];
    int          m_victim;
    int          m_miss;
    int          flush_idx;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void resetModel();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0;
            m_vbase[i] = '0;
            m_sbase[i] = 0;
            m_words[i] = 0;
        end
        m_victim  = 0;
        m_miss    = 0;
        flush_idx = -1;
    endfunction

    function automatic int usedCount();
        int n = 0;
        for (int i = 0; i < NENT; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic void modelLookup(input logic [31:0] vptr, output bit hit,
                                        output bit fault, output int slot);
        logic [31:0] diff;
        longint      offs;
        bit          found = 1'b0;
        fault = (vptr % WBYTES) != 0;
        hit   = 1'b0;
        slot  = 0;
        for (int i = 0; i < NENT; i++) begin
            diff = vptr - m_vbase[i];
            offs = longint'(diff / WBYTES);
            if (!found && m_valid[i] && offs < longint'(m_words[i])) begin
                found = 1'b1;
                slot  = (m_sbase[i] + int'(offs)) % NSLOTS;
            end
        end
        if (found && !fault && flush_idx < 0) hit = 1'b1;
        else slot = 0;
    endfunction

    function automatic void modelUpdate(input bit ready, input bit hit, input bit fault);
        int t;
        if (bus.req_valid && !hit && !fault && m_miss < 65535) m_miss++;
        if (bus.map_valid && ready && bus.map_words != 0) begin
            t = -1;
            for (int i = 0; i < NENT; i++) if (t < 0 && !m_valid[i]) t = i;
            if (t < 0) begin
                t = m_victim;
                m_victim = (m_victim + 1) % NENT;
            end
            m_valid[t] = 1'b1;
            m_vbase[t] = bus.map_vbase;
            m_sbase[t] = int'(bus.map_sbase);
            m_words[t] = int'(bus.map_words);
        end
        if (flush_idx >= 0) begin
            m_valid[flush_idx] = 1'b0;
            if (bus.flush) flush_idx = 0;
            else if (flush_idx == NENT - 1) flush_idx = -1;
            else flush_idx++;
        end else if (bus.flush) begin
            flush_idx = 0;
        end
    endfunction

    // One clock: check handshake before the edge, registered results after it.
    task automatic applyStimulus();
        bit ready, hit, fault, req;
        int slot;
        #1;
        ready = (flush_idx < 0) && !bus.flush;
        req   = bus.req_valid;
        checkOutput("map_ready", 32'(bus.map_ready), 32'(ready));
        modelLookup(bus.req_vptr, hit, fault, slot);
        modelUpdate(ready, hit, fault);
        @(posedge clk);
        #1;
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(req));
        if (req) begin
            checkOutput("rsp_hit", 32'(bus.rsp_hit), 32'(hit));
            checkOutput("rsp_fault", 32'(bus.rsp_fault), 32'(fault));
            checkOutput("rsp_slot", 32'(bus.rsp_slot), 32'(slot));
        end
        checkOutput("entries_used", 32'(bus.entries_used), 32'(usedCount()));
        checkOutput("miss_cnt", 32'(bus.miss_cnt), 32'(m_miss));
        bus.map_valid = 1'b0;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic doInstall(input logic [31:0] vb, input int sb, input int w);
        bus.map_valid = 1'b1;
        bus.map_vbase = vb;
        bus.map_sbase = 5'(sb);
        bus.map_words = 6'(w);
        applyStimulus();
    endtask

    task automatic doLookup(input logic [31:0] vptr);
        bus.req_valid = 1'b1;
        bus.req_vptr  = vptr;
        applyStimulus();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_hit"}, 32'(bus.rsp_hit), 32'd0);
        checkOutput({tag, "_rsp_fault"}, 32'(bus.rsp_fault), 32'd0);
        checkOutput({tag, "_rsp_slot"}, 32'(bus.rsp_slot), 32'd0);
        checkOutput({tag, "_used"}, 32'(bus.entries_used), 32'd0);
        checkOutput({tag, "_miss"}, 32'(bus.miss_cnt), 32'd0);
    endtask

    initial begin
        bus.map_valid = 1'b0;
        bus.map_vbase = '0;
        bus.map_sbase = '0;
        bus.map_words = '0;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_vptr  = '0;
        resetModel();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_map_ready", 32'(bus.map_ready), 32'd1);

        // Basic hit, miss and misaligned pointer
        doInstall(32'h1000, 4, 8);
        doLookup(32'h1008);
        checkOutput("plan_hit", 32'(bus.rsp_hit), 32'd1);
        checkOutput("plan_slot6", 32'(bus.rsp_slot), 32'd6);
        doLookup(32'h1020);
        checkOutput("plan_miss1", 32'(bus.miss_cnt), 32'd1);
        doLookup(32'h1006);
        checkOutput("plan_fault", 32'(bus.rsp_fault), 32'd1);
        checkOutput("plan_fault_miss", 32'(bus.miss_cnt), 32'd1);

        // Slot wrap and below-base pointer
        doInstall(32'h2000, 30, 4);
        doLookup(32'h2008);
        checkOutput("plan_wrap_slot", 32'(bus.rsp_slot), 32'd0);
        checkOutput("plan_wrap_hit", 32'(bus.rsp_hit), 32'd1);
        doLookup(32'h0FFC);
        checkOutput("plan_below_hit", 32'(bus.rsp_hit), 32'd0);

        // Fill, then round-robin replacement
        doInstall(32'h4000, 10, 4);
        doInstall(32'h5000, 12, 4);
        doInstall(32'h6000, 14, 4);
        doLookup(32'h1008);
        checkOutput("plan_replaced0", 32'(bus.rsp_hit), 32'd0);
        doInstall(32'h7000, 16, 4);
        doLookup(32'h2008);
        checkOutput("plan_replaced1", 32'(bus.rsp_hit), 32'd0);
        doLookup(32'h6004);
        checkOutput("plan_new_slot", 32'(bus.rsp_slot), 32'd15);
        checkOutput("plan_used4", 32'(bus.entries_used), 32'd4);

        // Install on the same edge as a lookup is not yet visible
        bus.req_valid = 1'b1;
        bus.req_vptr  = 32'h4000;
        bus.flush     = 1'b1;
        applyStimulus();
        repeat (NENT) applyStimulus();
        doInstall(32'h3000, 1, 4);
        doInstall(32'h8000, 2, 4);
        bus.req_valid = 1'b1;
        bus.req_vptr  = 32'h3000;
        doInstall(32'h3000, 9, 4);
        checkOutput("plan_pre_install", 32'(bus.rsp_slot), 32'd1);
        doInstall(32'h9000, 3, 4);
        doLookup(32'h3000);
        checkOutput("plan_overlap_slot", 32'(bus.rsp_slot), 32'd1);

        // Directed flush with all four entries valid
        bus.flush     = 1'b1;
        bus.map_valid = 1'b1;
        bus.map_vbase = 32'hA000;
        bus.map_words = 6'd4;
        applyStimulus();
        doLookup(32'h3000);
        checkOutput("plan_flush_miss", 32'(bus.rsp_hit), 32'd0);
        doInstall(32'hB000, 5, 4);
        applyStimulus();
        applyStimulus();
        checkOutput("plan_flush_used0", 32'(bus.entries_used), 32'd0);
        checkOutput("plan_flush_ready", 32'(bus.map_ready), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) < 35) begin
                bus.map_valid = 1'b1;
                bus.map_vbase = 32'h1000 * $urandom_range(7) + 32'(4 * $urandom_range(8));
                bus.map_sbase = 5'($urandom_range(31));
                bus.map_words = 6'($urandom_range(32));
            end
            if ($urandom_range(99) < 75) begin
                bus.req_valid = 1'b1;
                bus.req_vptr  = 32'h1000 * $urandom_range(7) + 32'(4 * $urandom_range(40))
                                - 32'(4 * $urandom_range(2));
                if ($urandom_range(9) == 0) bus.req_vptr = bus.req_vptr + 32'($urandom_range(3));
            end
            if ($urandom_range(99) < 4) bus.flush = 1'b1;
            applyStimulus();
        end

        // Asynchronous reset in the middle of a flush with a lookup in flight
        repeat (NENT) doInstall(32'hC000, 7, 8);
        bus.flush = 1'b1;
        applyStimulus();
        bus.req_valid = 1'b1;
        bus.req_vptr  = 32'hC004;
        #3;
        rst_n = 1'b0;
        #2;
        checkAllZero("midflush_reset");
        bus.req_valid = 1'b0;
        resetModel();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_ready", 32'(bus.map_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("post_reset_no_rsp", 32'(bus.rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tlb_window.md
# tlb_window

Multi-entry windowed translation table that maps word-aligned virtual pointers onto memory slot indices. It supersedes the single-base translator: up to ENTRIES independent windows (virtual base, slot base, length) are installed at run time. Lookups are registered with one-cycle latency and report hit, fault and a miss count. A sequenced flush clears the table. It sits between the core's load/store address path and the slot-indexed data memory.

## Interface
- MEM_SLOTS_COUNT, 32, data-memory slot count; SLOT_W = LOG2(MEM_SLOTS_COUNT)
- ENTRIES, 4, window entries (power of two, >=2); IDX_W = LOG2(ENTRIES)
- WORDSZ_BYTES, 4, bytes per slot (power of two)
- _clk  in  1  clock, rising edge
- _reset_n  in  1  asynchronous, active-low reset
- _map_valid  in  1  install request
- _map_vbase  in  32  window virtual base (byte address)
- _map_sbase  in  SLOT_W  first slot of the window
- _map_words  in  SLOT_W+1  window length in words
- map_ready_  out  1  install accepted when high with _map_valid
- _flush  in  1  start table clear (pulse)
- _req_valid  in  1  lookup request
- _req_vptr  in  32  lookup virtual pointer
- rsp_valid_  out  1  lookup result valid
- rsp_hit_  out  1  translation found
- rsp_fault_  out  1  misaligned pointer
- rsp_slot_n_  out  SLOT_W  translated slot (0 on miss or fault)
- entries_used_  out  IDX_W+1  number of valid entries
- miss_cnt_  out  16  saturating miss counter

## Operation
- Each entry holds valid, vbase, sbase, words. Reset clears every valid bit. Victim pointer resets to 0, miss_cnt_ to 0, FSM to IDLE.
- FSM states: IDLE and FLUSH.
  - IDLE -> FLUSH on _flush. The flush counter loads 0.
  - FLUSH clears entry[counter] each cycle. It returns to IDLE after clearing entry ENTRIES-1, so the flush takes ENTRIES cycles.
  - _flush while in FLUSH restarts the counter at 0.
- map_ready_ = 1 in IDLE with _flush low, else 0.
- Install (_map_valid & map_ready_):
  - Target is the lowest-index invalid entry. If all entries are valid, the target is entry[victim], and victim increments mod ENTRIES.
  - Victim does not move when an invalid entry is used.
  - _map_words == 0: the request is accepted and discarded. No entry and no pointer change.
- Lookup (_req_valid), evaluated against the table state before this cycle's install or flush:
  - fault = _req_vptr[LOG2(WORDSZ_BYTES)-1:0] != 0.
  - Per entry: offs = (_req_vptr - vbase) >> LOG2(WORDSZ_BYTES), in 32-bit unsigned wrap-around arithmetic. The entry matches if valid and offs < words.
  - Multiple matches: the lowest index wins.
  - slot = (sbase + offs[SLOT_W-1:0]) mod MEM_SLOTS_COUNT. The slot index wraps.
  - hit = match & !fault. A fault forces hit = 0 and slot = 0.
  - In FLUSH, every lookup misses (hit = 0). Fault is still reported.
  - A miss (no hit, no fault) increments miss_cnt_, which saturates at 0xFFFF. A fault alone does not count as a miss.
- entries_used_ is the count of valid bits. It is registered and updated the same cycle the table changes.

## Timing
- Lookup latency is one cycle. A request at edge N gives rsp_valid_/rsp_hit_/rsp_fault_/rsp_slot_n_ after edge N+1. rsp_valid_ is 0 in any cycle following no request.
- Back-to-back lookups are accepted every cycle. No backpressure on lookup.
- An install at edge N is visible to a lookup issued at edge N+1, not to one at edge N.
- A flush pulse at edge N sets map_ready_ = 0 from that cycle. Entry k is cleared at edge N+1+k, and IDLE is re-entered after edge N+ENTRIES.
- Reset values of all outputs are 0 except map_ready_, which is 1 immediately after _reset_n deasserts. Asserting _reset_n mid-flush or mid-lookup clears everything asynchronously, and no response emerges.

## Test plan
- Install (vbase 0x1000, sbase 4, words 8). Lookup 0x1008 -> next cycle rsp_hit_ = 1, rsp_slot_n_ = 6. Lookup 0x1020 -> miss, miss_cnt_ = 1.
- Lookup 0x1006 with that window installed -> rsp_fault_ = 1, rsp_hit_ = 0, rsp_slot_n_ = 0, miss_cnt_ unchanged.
- Wrap: install (0x2000, sbase 30, words 4). Lookup 0x2008 -> slot 0. Lookup 0x0FFC with no window covering it -> miss. Vptr below vbase wraps to a huge offs, so no hit.
- Fill all 4 entries, then install a 5th -> entry 0 replaced, victim = 1. A 6th install replaces entry 1. entries_used_ stays 4.
- Overlap: entries 0 and 2 both cover 0x3000, with sbase 1 and 9 -> slot 1 is returned.
- Flush with 4 entries valid -> map_ready_ is 0 for 4 cycles. A lookup during flush misses. entries_used_ reaches 0. _map_valid during flush is not accepted. Async reset asserted mid-flush -> all outputs 0 on the following sample.
